// File: rtl/lcd_pkg.sv
// lcd_pkg -- shared types and constants for the LCD bus-timing engine.
//   lcd_bus_state_t : bus drive phases (idle, setup, enable, hold, wait)
//   lcd_instr_t     : one 9-bit LCD instruction {rs, data[7:0]}
//   LCD_CMD_CLEAR / LCD_CMD_HOME : commands needing the long execution wait
//   LCD_CNT_W       : width of the shared delay counter
// Optional feature macro used by the top: LCD_LONG_DELAY_EN
package lcd_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ENABLE,
      S_HOLD,
      S_WAIT
   } lcd_bus_state_t;

   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } lcd_instr_t;

   localparam logic [8:0] LCD_CMD_CLEAR = 9'h001;
   localparam logic [8:0] LCD_CMD_HOME  = 9'h002;
   localparam int         LCD_CNT_W     = 20;

   // Truncate a cycle count to counter width.
   function automatic logic [LCD_CNT_W-1:0] cnt_of(input int unsigned n);
      logic [31:0] t;
      t = n;
      return t[LCD_CNT_W-1:0];
   endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// lcd_delay_counter -- loadable down counter shared by all timed bus phases.
//   Clock_50 : clock
//   Resetn   : async active-low reset (value -> 0)
//   load     : load load_val this edge (wins over counting)
//   load_val : value to load
//   value    : current count
//   zero     : value == 0
// Counts down and parks at 0; it never wraps, so the FSM reloads it.
module lcd_delay_counter
   import lcd_pkg::*;
(
   input  logic                 Clock_50,
   input  logic                 Resetn,
   input  logic                 load,
   input  logic [LCD_CNT_W-1:0] load_val,
   output logic [LCD_CNT_W-1:0] value,
   output logic                 zero
);

   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn)
         value <= '0;
      else if (load)
         value <= load_val;
      else if (value != '0)
         value <= value - 1'b1;
   end

   assign zero = (value == '0);

endmodule

// File: rtl/lcd_bus_timer.sv
// lcd_bus_timer -- drives an HD44780-style 8-bit LCD bus for one instruction
// per LCD_start pulse: setup, enable pulse, hold, execution wait, then a
// one-cycle LCD_done.
//   Clock_50                in  clock
//   Resetn                  in  async active-low reset
//   LCD_start               in  request, only sampled while idle
//   LCD_instruction[8:0]    in  [8]=RS, [7:0]=byte
//   LCD_done                out completion pulse
//   LCD_power/back_light    out constant 1
//   LCD_read_write          out constant 0 (write only)
//   LCD_enable              out E strobe
//   LCD_command_data_select out RS
//   LCD_data_io[7:0]        out data byte
// Macro LCD_LONG_DELAY_EN: clear/home commands use LONG_LCD_delay_count.
module lcd_bus_timer
   import lcd_pkg::*;
#(
   parameter int unsigned SETUP_CYCLES         = 2,
   parameter int unsigned EN_HIGH_CYCLES       = 12,
   parameter int unsigned HOLD_CYCLES          = 1,
   parameter logic [17:0] MAX_LCD_delay_count  = 18'h3FFFE,
   parameter logic [19:0] LONG_LCD_delay_count = 20'h4A380
)(
   input  logic       Clock_50,
   input  logic       Resetn,
   input  logic       LCD_start,
   input  logic [8:0] LCD_instruction,
   output logic       LCD_done,
   output logic       LCD_power,
   output logic       LCD_back_light,
   output logic       LCD_read_write,
   output logic       LCD_enable,
   output logic       LCD_command_data_select,
   output logic [7:0] LCD_data_io
);

   lcd_bus_state_t       state, state_nxt;
   lcd_instr_t           instr_q, instr_nxt;
   logic                 en_nxt, done_nxt;
   logic                 cnt_load, cnt_zero;
   logic [LCD_CNT_W-1:0] cnt_load_val, cnt_value_unused, wait_val;

   lcd_delay_counter u_cnt (
      .Clock_50 (Clock_50),
      .Resetn   (Resetn),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .value    (cnt_value_unused),
      .zero     (cnt_zero)
   );

   // The wait phase counts from the full delay (not delay-1): the extra
   // edge is the one that registers LCD_done, giving a total latency of
   // SETUP+EN_HIGH+HOLD+delay+1 edges from the accepting edge.
`ifdef LCD_LONG_DELAY_EN
   always_comb begin
      if (instr_q == LCD_CMD_CLEAR || instr_q == LCD_CMD_HOME)
         wait_val = LONG_LCD_delay_count;
      else
         wait_val = LCD_CNT_W'(MAX_LCD_delay_count);
   end
`else
   logic unused_long;
   assign unused_long = ^{LONG_LCD_delay_count, LCD_CMD_CLEAR, LCD_CMD_HOME};
   assign wait_val    = LCD_CNT_W'(MAX_LCD_delay_count);
`endif

   always_comb begin
      state_nxt    = state;
      instr_nxt    = instr_q;
      en_nxt       = LCD_enable;
      done_nxt     = 1'b0;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      case (state)
         S_IDLE: if (LCD_start) begin
            instr_nxt    = LCD_instruction;
            cnt_load     = 1'b1;
            cnt_load_val = cnt_of(SETUP_CYCLES - 1);
            state_nxt    = S_SETUP;
         end
         S_SETUP: if (cnt_zero) begin
            en_nxt       = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = cnt_of(EN_HIGH_CYCLES - 1);
            state_nxt    = S_ENABLE;
         end
         S_ENABLE: if (cnt_zero) begin
            en_nxt       = 1'b0;
            cnt_load     = 1'b1;
            cnt_load_val = cnt_of(HOLD_CYCLES - 1);
            state_nxt    = S_HOLD;
         end
         S_HOLD: if (cnt_zero) begin
            cnt_load     = 1'b1;
            cnt_load_val = wait_val;
            state_nxt    = S_WAIT;
         end
         S_WAIT: if (cnt_zero) begin
            done_nxt     = 1'b1;
            state_nxt    = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         state          <= S_IDLE;
         instr_q        <= '0;
         LCD_enable     <= 1'b0;
         LCD_done       <= 1'b0;
         LCD_power      <= 1'b1;
         LCD_back_light <= 1'b1;
         LCD_read_write <= 1'b0;
      end else begin
         state          <= state_nxt;
         instr_q        <= instr_nxt;
         LCD_enable     <= en_nxt;
         LCD_done       <= done_nxt;
         LCD_power      <= 1'b1;
         LCD_back_light <= 1'b1;
         LCD_read_write <= 1'b0;
      end
   end

   assign LCD_command_data_select = instr_q.rs;
   assign LCD_data_io             = instr_q.data;

endmodule

// File: tb/tb_lcd_bus_timer.sv
module tb_lcd_bus_timer;
   import lcd_pkg::*;

   localparam int S = 2, E = 3, H = 1, D = 5, L = 20;
   localparam int LAT = S + E + H + D + 1;   // 12
`ifdef LCD_LONG_DELAY_EN
   localparam int LAT_CLR = S + E + H + L + 1; // 27
`else
   localparam int LAT_CLR = LAT;
`endif

   logic       clk = 1'b0;
   logic       rstn, start;
   logic [8:0] instr;
   logic       done, pwr, bl, rw, en, rs;
   logic [7:0] dio;
   int         n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;

   lcd_bus_timer #(
      .SETUP_CYCLES(S), .EN_HIGH_CYCLES(E), .HOLD_CYCLES(H),
      .MAX_LCD_delay_count(18'd5), .LONG_LCD_delay_count(20'd20)
   ) dut (
      .Clock_50(clk), .Resetn(rstn), .LCD_start(start), .LCD_instruction(instr),
      .LCD_done(done), .LCD_power(pwr), .LCD_back_light(bl), .LCD_read_write(rw),
      .LCD_enable(en), .LCD_command_data_select(rs), .LCD_data_io(dio)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Issue one instruction and check every edge up to the done pulse.
   // ign1/ign2: edges (relative to the accepting edge) at which a stray
   // start is presented; 0 means none.
   task automatic txn(input logic [8:0] ins, input int lat, input int ign1, input int ign2);
      @(negedge clk); start = 1'b1; instr = ins;
      @(posedge clk); #1 start = 1'b0; instr = 9'h1AA;
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         if (k == ign1 || k == ign2) begin start = 1'b1; instr = 9'h0FF; end
         @(posedge clk); #1 start = 1'b0;
         chk($sformatf("en@%0d", k), en, (k >= S && k < S + E));
         chk($sformatf("done@%0d", k), done, (k == lat));
         chk($sformatf("rs@%0d", k), rs, ins[8]);
         chk($sformatf("dio@%0d", k), dio, ins[7:0]);
         chk($sformatf("rw@%0d", k), rw, 1'b0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0; start = 1'b0; instr = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_en", en, 0);   chk("rst_done", done, 0); chk("rst_rw", rw, 0);
      chk("rst_rs", rs, 0);   chk("rst_dio", dio, 0);   chk("rst_pwr", pwr, 1);
      chk("rst_bl", bl, 1);
      @(negedge clk) rstn = 1'b1;

      // 1: async reset mid enable pulse
      @(negedge clk); start = 1'b1; instr = 9'h157;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("t1_en_pre", en, 1);
      #2 rstn = 1'b0;
      #1 chk("t1_en_async", en, 0);
      chk("t1_dio", dio, 0); chk("t1_done", done, 0); chk("t1_pwr", pwr, 1);
      @(negedge clk) rstn = 1'b1;
      @(posedge clk); #1;
      chk("t1_state", dut.state, S_IDLE);
      chk("t1_en_post", en, 0);

      // 2: data write
      txn(9'h157, LAT, 0, 0);
      @(posedge clk); #1 chk("t2_single_done", done, 0);

      // 4: stray starts in S_ENABLE (edge 3) and S_WAIT (edge 8)
      txn(9'h03C, LAT, 3, 8);
      @(posedge clk); #1 chk("t4_single_done", done, 0);
      chk("t4_bus_kept", dio, 8'h3C);
      repeat (3) @(posedge clk);
      #1 chk("t4_still_idle", dut.state, S_IDLE);

      // 3: command write, then 5: back-to-back start in the done cycle
      txn(9'h080, LAT, 0, 0);
      txn(9'h165, LAT, 0, 0);
      @(posedge clk); #1 chk("t5_single_done", done, 0);

      // 6: clear (long wait when enabled) and a plain command
      txn(9'h001, LAT_CLR, 0, 0);
      txn(9'h006, LAT, 0, 0);
      @(posedge clk); #1 chk("t6_single_done", done, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
